draw_job_scheduler: RTL and testbench

- Sequences all sprite draws on the shared card-drawing engine: card faces, card backs, and the P1/P2 winner banners.
- Requesters (game FSM, deal logic) push draw jobs into a small FIFO; the block runs one job at a time.
- Per job it re-arms the engine with a reset pulse, applies kind/num/suit/pos, gates VGA plot while pixels are valid, and waits for engine done.
- Adds a watchdog, illegal-job filtering and completion/error status.

---
 rtl/draw_pkg.sv | 33 +++
 rtl/draw_job_fifo.sv | 76 +++++++
 rtl/draw_job_scheduler.sv | 159 +++++++++++++++
 tb/tb_draw_job_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared encodings, job record layout and the illegal-job filter for the sprite
// draw scheduler.
package draw_pkg;

   localparam logic [2:0] KIND_FACE = 3'd0;
   localparam logic [2:0] KIND_BACK = 3'd1;
   localparam logic [2:0] KIND_P1   = 3'd2;
   localparam logic [2:0] KIND_P2   = 3'd3;

   localparam logic [3:0] POS_MAX = 4'd10;
   localparam logic [3:0] NUM_MAX = 4'd13;

   localparam int unsigned JOB_W = 13;

   typedef struct packed {
      logic [2:0] kind;
      logic [3:0] num;
      logic [1:0] suit;
      logic [3:0] pos;
   } job_t;

   typedef enum logic [1:0] {StIdle, StClear, StSettle, StDraw} state_e;

   function automatic logic job_illegal(input job_t job);
      logic kind_ok;
      logic face_bad;
      kind_ok  = (job.kind == KIND_FACE) || (job.kind == KIND_BACK) ||
                 (job.kind == KIND_P1)   || (job.kind == KIND_P2);
      face_bad = (job.kind == KIND_FACE) && ((job.num == 4'd0) || (job.num > NUM_MAX));
      return !kind_ok || (job.pos > POS_MAX) || face_bad;
   endfunction

endpackage

// File: rtl/draw_job_fifo.sv
// Synchronous DEPTH x JOB_W job FIFO; the head entry is read directly from the
// storage flops so the consumer sees it the cycle it pops.
module draw_job_fifo
   import draw_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [JOB_W-1:0] wdata_i,
   input  logic             pop_i,
   output logic [JOB_W-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [JOB_W-1:0] mem_q [DEPTH];
   logic [JOB_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read once written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/draw_job_scheduler.sv
// Runs queued sprite draw jobs one at a time on the shared card-drawing engine:
// re-arm, settle, plot until done, with watchdog and illegal-job filtering.
module draw_job_scheduler
   import draw_pkg::*;
#(
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned CLR_CYCLES    = 2,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned TIMEOUT       = 4095
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_kind,
   input  logic [3:0] req_num,
   input  logic [1:0] req_suit,
   input  logic [3:0] req_pos,
   output logic       eng_reset,
   output logic [2:0] eng_kind,
   output logic [3:0] eng_num,
   output logic [1:0] eng_suit,
   output logic [3:0] eng_pos,
   input  logic       eng_done,
   output logic       plot_en,
   output logic       busy,
   output logic [7:0] jobs_done,
   output logic       err_timeout,
   output logic       err_illegal,
   input  logic       flush
);

   localparam logic [11:0] CLR_LAST    = 12'(CLR_CYCLES - 1);
   localparam logic [11:0] SETTLE_LAST = 12'(SETTLE_CYCLES - 1);
   localparam logic [11:0] TO_LAST     = 12'(TIMEOUT - 1);

   state_e      state_q, state_d;
   job_t        job_q, job_d;
   logic [11:0] cnt_q, cnt_d;
   logic [7:0]  jobs_done_q, jobs_done_d;
   logic        err_timeout_q, err_timeout_d;
   logic        err_illegal_q, err_illegal_d;

   job_t req_job, head_job;
   logic full, empty, accept, illegal, fifo_push, pop;

   assign req_job   = '{kind: req_kind, num: req_num, suit: req_suit, pos: req_pos};
   assign illegal   = job_illegal(req_job);
   assign req_ready = !full && !reset;
   // A push coinciding with flush is dropped outright.
   assign accept    = req_valid && req_ready && !flush;
   assign fifo_push = accept && !illegal;

   draw_job_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear_i (flush),
      .push_i  (fifo_push),
      .wdata_i (req_job),
      .pop_i   (pop),
      .rdata_o (head_job),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      state_d       = state_q;
      job_d         = job_q;
      cnt_d         = cnt_q;
      pop           = 1'b0;
      jobs_done_d   = jobs_done_q;
      err_timeout_d = err_timeout_q;
      err_illegal_d = err_illegal_q || (accept && illegal);
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop     = 1'b1;
               job_d   = head_job;
               cnt_d   = '0;
               state_d = StClear;
            end
         end
         StClear: begin
            if (cnt_q == CLR_LAST) begin
               cnt_d   = '0;
               state_d = StSettle;
            end else begin
               cnt_d = cnt_q + 12'd1;
            end
         end
         StSettle: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = StDraw;
            end else begin
               cnt_d = cnt_q + 12'd1;
            end
         end
         StDraw: begin
            // Completion wins over a watchdog expiry in the same cycle.
            if (eng_done) begin
               jobs_done_d = jobs_done_q + 8'd1;
               cnt_d       = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  job_d   = head_job;
                  state_d = StClear;
               end else begin
                  state_d = StIdle;
               end
            end else if (cnt_q == TO_LAST) begin
               err_timeout_d = 1'b1;
               cnt_d         = '0;
               state_d       = StIdle;
            end else begin
               cnt_d = cnt_q + 12'd1;
            end
         end
      endcase
      if (flush) begin
         pop     = 1'b0;
         job_d   = job_q;
         cnt_d   = '0;
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         job_q         <= '0;
         cnt_q         <= '0;
         jobs_done_q   <= '0;
         err_timeout_q <= 1'b0;
         err_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         job_q         <= job_d;
         cnt_q         <= cnt_d;
         jobs_done_q   <= jobs_done_d;
         err_timeout_q <= err_timeout_d;
         err_illegal_q <= err_illegal_d;
      end
   end

   assign eng_reset   = (state_q == StIdle) || (state_q == StClear);
   assign plot_en     = (state_q == StDraw);
   assign busy        = (state_q != StIdle) || !empty;
   assign eng_kind    = job_q.kind;
   assign eng_num     = job_q.num;
   assign eng_suit    = job_q.suit;
   assign eng_pos     = job_q.pos;
   assign jobs_done   = jobs_done_q;
   assign err_timeout = err_timeout_q;
   assign err_illegal = err_illegal_q;

endmodule

// File: tb/tb_draw_job_scheduler.sv
// Directed bench for draw_job_scheduler: single job timing, FIFO back-pressure,
// illegal filtering, watchdog, flush, reset and completion-counter wrap.
module tb_draw_job_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_kind;
   logic [3:0] req_num;
   logic [1:0] req_suit;
   logic [3:0] req_pos;
   logic       eng_reset;
   logic [2:0] eng_kind;
   logic [3:0] eng_num;
   logic [1:0] eng_suit;
   logic [3:0] eng_pos;
   logic       eng_done;
   logic       plot_en;
   logic       busy;
   logic [7:0] jobs_done;
   logic       err_timeout;
   logic       err_illegal;
   logic       flush;

   int vectors     = 0;
   int miscompares = 0;
   int gap;

   draw_job_scheduler #(
      .DEPTH         (8),
      .CLR_CYCLES    (2),
      .SETTLE_CYCLES (2),
      .TIMEOUT       (20)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_kind    (req_kind),
      .req_num     (req_num),
      .req_suit    (req_suit),
      .req_pos     (req_pos),
      .eng_reset   (eng_reset),
      .eng_kind    (eng_kind),
      .eng_num     (eng_num),
      .eng_suit    (eng_suit),
      .eng_pos     (eng_pos),
      .eng_done    (eng_done),
      .plot_en     (plot_en),
      .busy        (busy),
      .jobs_done   (jobs_done),
      .err_timeout (err_timeout),
      .err_illegal (err_illegal),
      .flush       (flush)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_job(input logic [2:0] k, input logic [3:0] n, input logic [1:0] s,
                           input logic [3:0] p);
      int t;
      t         = 0;
      req_kind  = k;
      req_num   = n;
      req_suit  = s;
      req_pos   = p;
      req_valid = 1'b1;
      while (!req_ready && t < 200) begin
         tick();
         t++;
      end
      check("push_ready", 16'(req_ready), 16'd1);
      tick();
      req_valid = 1'b0;
   endtask

   // Waits for plot_en, checks the job fields, then completes it with one eng_done cycle.
   task automatic run_job(input logic [2:0] k, input logic [3:0] n, input logic [1:0] s,
                          input logic [3:0] p, output int g);
      g = 0;
      while (!plot_en && g < 200) begin
         tick();
         g++;
      end
      check("job_plot", 16'(plot_en), 16'd1);
      check("job_rst", 16'(eng_reset), 16'd0);
      check("job_kind", 16'(eng_kind), 16'(k));
      check("job_num", 16'(eng_num), 16'(n));
      check("job_suit", 16'(eng_suit), 16'(s));
      check("job_pos", 16'(eng_pos), 16'(p));
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      check("job_end_plot", 16'(plot_en), 16'd0);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 4000) begin
         tick();
         t++;
      end
      check("idle", 16'(busy), 16'd0);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = 1'b0;
      eng_done  = 1'b0;
      flush     = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_kind  = '0;
      req_num   = '0;
      req_suit  = '0;
      req_pos   = '0;
      eng_done  = 1'b0;
      flush     = 1'b0;
      tick();
      tick();

      // Reset values
      check("rst_ready", 16'(req_ready), 16'd0);
      check("rst_eng_reset", 16'(eng_reset), 16'd1);
      check("rst_plot", 16'(plot_en), 16'd0);
      check("rst_eng_fields", 16'({eng_kind, eng_num, eng_suit, eng_pos}), 16'd0);
      check("rst_jobs_done", 16'(jobs_done), 16'd0);
      check("rst_errs", 16'({err_timeout, err_illegal}), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
      reset = 1'b0;
      tick();
      check("post_rst_ready", 16'(req_ready), 16'd1);

      // Single face job: 2 clear cycles, 2 settle cycles, plot until done
      push_job(3'd0, 4'd1, 2'd3, 4'd4);
      tick();
      check("t1_clr0_rst", 16'(eng_reset), 16'd1);
      check("t1_clr0_num", 16'(eng_num), 16'd1);
      check("t1_clr0_suit", 16'(eng_suit), 16'd3);
      check("t1_clr0_pos", 16'(eng_pos), 16'd4);
      tick();
      check("t1_clr1_rst", 16'(eng_reset), 16'd1);
      tick();
      check("t1_set0", 16'({eng_reset, plot_en}), 16'd0);
      tick();
      check("t1_set1", 16'({eng_reset, plot_en}), 16'd0);
      tick();
      check("t1_draw0_plot", 16'(plot_en), 16'd1);
      tick();
      eng_done = 1'b1;
      check("t1_done_cycle_plot", 16'(plot_en), 16'd1);
      check("t1_draw_fields", 16'({eng_kind, eng_num, eng_suit, eng_pos}),
            16'({3'd0, 4'd1, 2'd3, 4'd4}));
      tick();
      eng_done = 1'b0;
      check("t1_after_plot", 16'(plot_en), 16'd0);
      check("t1_jobs_done", 16'(jobs_done), 16'd1);
      check("t1_busy", 16'(busy), 16'd0);

      // Nine back-to-back jobs with the engine stalled
      do_reset();
      for (int i = 0; i < 9; i++) begin
         push_job(3'd0, 4'(i + 1), 2'(i % 4), 4'(i));
      end
      check("t2_full_ready", 16'(req_ready), 16'd0);
      check("t2_busy", 16'(busy), 16'd1);
      run_job(3'd0, 4'd1, 2'd0, 4'd0, gap);
      check("t2_ready_after_pop", 16'(req_ready), 16'd1);
      for (int i = 1; i < 9; i++) begin
         run_job(3'd0, 4'(i + 1), 2'(i % 4), 4'(i), gap);
         check("t2_gap", 16'(gap), 16'd4);
      end
      tick();
      check("t2_jobs_done", 16'(jobs_done), 16'd9);
      check("t2_busy_end", 16'(busy), 16'd0);
      check("t2_eng_reset_end", 16'(eng_reset), 16'd1);

      // Illegal jobs are swallowed
      check("t3_illegal_pre", 16'(err_illegal), 16'd0);
      push_job(3'd5, 4'd1, 2'd0, 4'd0);
      check("t3_illegal_set", 16'(err_illegal), 16'd1);
      check("t3_busy_kind", 16'(busy), 16'd0);
      push_job(3'd0, 4'd1, 2'd0, 4'd12);
      check("t3_busy_pos", 16'(busy), 16'd0);
      push_job(3'd0, 4'd0, 2'd0, 4'd0);
      check("t3_busy_num0", 16'(busy), 16'd0);
      push_job(3'd0, 4'd14, 2'd0, 4'd0);
      tick();
      tick();
      check("t3_busy_num14", 16'(busy), 16'd0);
      check("t3_eng_untouched", 16'({eng_kind, eng_num, eng_suit, eng_pos}),
            16'({3'd0, 4'd9, 2'd0, 4'd8}));
      check("t3_jobs_done", 16'(jobs_done), 16'd9);
      check("t3_timeout_clear", 16'(err_timeout), 16'd0);

      // Watchdog: 20 DRAW cycles then abort, next job runs normally
      push_job(3'd2, 4'd0, 2'd0, 4'd10);
      push_job(3'd3, 4'd0, 2'd1, 4'd0);
      gap = 0;
      while (!plot_en && gap < 200) begin
         tick();
         gap++;
      end
      check("t4_kind", 16'(eng_kind), 16'd2);
      check("t4_pos", 16'(eng_pos), 16'd10);
      gap = 0;
      while (plot_en && gap < 200) begin
         gap++;
         tick();
      end
      check("t4_draw_cycles", 16'(gap), 16'd20);
      check("t4_err_timeout", 16'(err_timeout), 16'd1);
      check("t4_eng_reset", 16'(eng_reset), 16'd1);
      check("t4_jobs_done", 16'(jobs_done), 16'd9);
      run_job(3'd3, 4'd0, 2'd1, 4'd0, gap);
      check("t4_next_gap", 16'(gap), 16'd5);
      check("t4_jobs_done_next", 16'(jobs_done), 16'd10);

      // Flush mid-DRAW with three queued and a concurrent push
      for (int i = 1; i < 5; i++) begin
         push_job(3'd1, 4'd0, 2'd0, 4'(i));
      end
      gap = 0;
      while (!plot_en && gap < 200) begin
         tick();
         gap++;
      end
      check("t5_draw_pos", 16'(eng_pos), 16'd1);
      flush     = 1'b1;
      req_valid = 1'b1;
      req_kind  = 3'd1;
      req_num   = 4'd0;
      req_suit  = 2'd0;
      req_pos   = 4'd5;
      tick();
      flush     = 1'b0;
      req_valid = 1'b0;
      check("t5_plot", 16'(plot_en), 16'd0);
      check("t5_eng_reset", 16'(eng_reset), 16'd1);
      check("t5_busy", 16'(busy), 16'd0);
      check("t5_jobs_done", 16'(jobs_done), 16'd10);
      check("t5_errs_kept", 16'({err_timeout, err_illegal}), 16'd3);
      tick();
      tick();
      tick();
      check("t5_busy_later", 16'(busy), 16'd0);
      check("t5_plot_later", 16'(plot_en), 16'd0);

      // Reset during CLEAR
      push_job(3'd1, 4'd5, 2'd2, 4'd7);
      tick();
      check("t6_in_clear_rst", 16'(eng_reset), 16'd1);
      check("t6_in_clear_pos", 16'(eng_pos), 16'd7);
      reset = 1'b1;
      tick();
      check("t6_fields", 16'({eng_kind, eng_num, eng_suit, eng_pos}), 16'd0);
      check("t6_ctrl", 16'({eng_reset, plot_en, busy, req_ready}), 16'b1000);
      check("t6_jobs_done", 16'(jobs_done), 16'd0);
      check("t6_errs", 16'({err_timeout, err_illegal}), 16'd0);
      reset = 1'b0;
      tick();
      check("t6_idle_after", 16'(busy), 16'd0);

      // Completion counter wrap
      eng_done = 1'b1;
      for (int i = 0; i < 255; i++) begin
         push_job(3'd1, 4'd0, 2'd0, 4'd0);
      end
      wait_idle();
      check("t7_jobs_255", 16'(jobs_done), 16'd255);
      push_job(3'd1, 4'd0, 2'd0, 4'd0);
      wait_idle();
      check("t7_jobs_wrap", 16'(jobs_done), 16'd0);
      eng_done = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
